// File: rtl/sddt_cmd_pkg.sv
// Shared command-stream definitions for the SDDT command path: widths, REF opcode, arbiter states.
package sddt_cmd_pkg;

    localparam int CMD_W    = 128;
    localparam int CMD_OP_W = 4;

    localparam logic [CMD_OP_W-1:0] CMD_OP_REF = 4'h4;

    typedef enum logic [1:0] {
        IDLE,
        REF_WAIT,
        REF_HOLD
    } arb_state_e;

    // REF command beat: opcode in the low nibble, everything else zero.
    function automatic logic [CMD_W-1:0] ref_word();
        return {{(CMD_W-CMD_OP_W){1'b0}}, CMD_OP_REF};
    endfunction

endpackage

// File: rtl/sddt_ref_timer.sv
// tREFI interval counter with a saturating owed-REF counter and a sticky overflow flag.
module sddt_ref_timer #(
    parameter int REF_INTERVAL = 2340,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ref_en,
    input  logic       ref_take,
    output logic [3:0] ref_pending,
    output logic       ref_overflow,
    output logic       at_max
);

    localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(REF_INTERVAL - 1);
    localparam logic [3:0]    PEND_MAX   = 4'(MAX_POSTPONE);

    logic [TW-1:0] timer_q;
    logic          tick;

    assign tick   = ref_en && (timer_q == TIMER_LAST);
    assign at_max = (ref_pending == PEND_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            ref_pending  <= '0;
            ref_overflow <= 1'b0;
        end else if (!ref_en) begin
            timer_q     <= '0;
            ref_pending <= '0;
        end else begin
            timer_q <= tick ? '0 : timer_q + 1'b1;
            // A tick and a take in the same cycle cancel out.
            if (tick && !ref_take && !at_max)
                ref_pending <= ref_pending + 1'b1;
            else if (!tick && ref_take)
                ref_pending <= ref_pending - 1'b1;
            if (tick && at_max)
                ref_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/sddt_ref_cmd_arbiter.sv
// Merges host command beats with periodic REF commands ahead of the cmd_scheduler S_AXIS_CMD port.
// Optional SDDT_REF_ARB_STATS_EN adds issued/forced REF counters.
module sddt_ref_cmd_arbiter
    import sddt_cmd_pkg::*;
#(
    parameter int REF_INTERVAL = 2340,
    parameter int MAX_POSTPONE = 8,
    parameter int REF_HOLDOFF  = 105
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_en,
    input  logic [CMD_W-1:0] S_AXIS_HOST_CMD_tdata,
    input  logic             S_AXIS_HOST_CMD_tvalid,
    output logic             S_AXIS_HOST_CMD_tready,
    output logic [CMD_W-1:0] M_AXIS_CMD_tdata,
    output logic             M_AXIS_CMD_tvalid,
    input  logic             M_AXIS_CMD_tready,
    output logic [3:0]       ref_pending,
    output logic             ref_overflow
`ifdef SDDT_REF_ARB_STATS_EN
    ,
    output logic [31:0]      ref_issued_cnt,
    output logic [31:0]      ref_forced_cnt
`endif
);

    localparam int HW = (REF_HOLDOFF > 1) ? $clog2(REF_HOLDOFF) : 1;

    arb_state_e      state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            rst_done_q;
    logic            loadable, out_accept, at_max;
    logic            load_ref, load_host, force_grant, host_ready;

    assign loadable   = !M_AXIS_CMD_tvalid || M_AXIS_CMD_tready;
    assign out_accept = M_AXIS_CMD_tvalid && M_AXIS_CMD_tready;
    assign S_AXIS_HOST_CMD_tready = host_ready;

    sddt_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .ref_en       (ref_en),
        .ref_take     (load_ref),
        .ref_pending  (ref_pending),
        .ref_overflow (ref_overflow),
        .at_max       (at_max)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        load_ref    = 1'b0;
        load_host   = 1'b0;
        force_grant = 1'b0;
        host_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_done_q && loadable) begin
                    if (at_max) begin
                        load_ref    = 1'b1;
                        force_grant = 1'b1;
                    end else begin
                        host_ready = 1'b1;
                        if (S_AXIS_HOST_CMD_tvalid)
                            load_host = 1'b1;
                        else if (ref_pending != 4'd0)
                            load_ref = 1'b1;
                    end
                    if (load_ref)
                        state_d = REF_WAIT;
                end
            end
            REF_WAIT: begin
                if (out_accept) begin
                    if (REF_HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REF_HOLD;
                        hold_d  = HW'(REF_HOLDOFF - 1);
                    end
                end
            end
            REF_HOLD: begin
                if (hold_q == '0)
                    state_d = IDLE;
                else
                    hold_d = hold_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rst_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_AXIS_CMD_tvalid <= 1'b0;
            M_AXIS_CMD_tdata  <= '0;
        end else if (load_ref) begin
            M_AXIS_CMD_tvalid <= 1'b1;
            M_AXIS_CMD_tdata  <= ref_word();
        end else if (load_host) begin
            M_AXIS_CMD_tvalid <= 1'b1;
            M_AXIS_CMD_tdata  <= S_AXIS_HOST_CMD_tdata;
        end else if (M_AXIS_CMD_tready) begin
            M_AXIS_CMD_tvalid <= 1'b0;
        end
    end

`ifdef SDDT_REF_ARB_STATS_EN
    // The output register only ever holds the REF beat while in REF_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_issued_cnt <= '0;
            ref_forced_cnt <= '0;
        end else begin
            if (state_q == REF_WAIT && out_accept)
                ref_issued_cnt <= ref_issued_cnt + 1'b1;
            if (force_grant)
                ref_forced_cnt <= ref_forced_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sddt_ref_cmd_arbiter.sv
// Directed bench for sddt_ref_cmd_arbiter (REF_INTERVAL=16, MAX_POSTPONE=4, REF_HOLDOFF=3).
module tb_sddt_ref_cmd_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ref_en;
    logic [127:0] h_data;
    logic         h_valid;
    logic         h_ready;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [3:0]   ref_pending;
    logic         ref_overflow;
`ifdef SDDT_REF_ARB_STATS_EN
    logic [31:0]  ref_issued_cnt;
    logic [31:0]  ref_forced_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] REF_W = 128'h4;

    always #5 clk = ~clk;

    sddt_ref_cmd_arbiter #(
        .REF_INTERVAL (16),
        .MAX_POSTPONE (4),
        .REF_HOLDOFF  (3)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ref_en                 (ref_en),
        .S_AXIS_HOST_CMD_tdata  (h_data),
        .S_AXIS_HOST_CMD_tvalid (h_valid),
        .S_AXIS_HOST_CMD_tready (h_ready),
        .M_AXIS_CMD_tdata       (m_data),
        .M_AXIS_CMD_tvalid      (m_valid),
        .M_AXIS_CMD_tready      (m_ready),
        .ref_pending            (ref_pending),
`ifdef SDDT_REF_ARB_STATS_EN
        .ref_issued_cnt         (ref_issued_cnt),
        .ref_forced_cnt         (ref_forced_cnt),
`endif
        .ref_overflow           (ref_overflow)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    function automatic logic [127:0] beat(input int n);
        return {4{32'hC000_0000 + n}};
    endfunction

    initial begin
        rst_n   = 1'b0;
        ref_en  = 1'b0;
        h_data  = '0;
        h_valid = 1'b0;
        m_ready = 1'b0;
        do_reset();

        check("rst_m_valid", m_valid, 0);
        check("rst_pending", ref_pending, 0);
        check("rst_overflow", ref_overflow, 0);
        check("rst_h_ready", h_ready, 1);

        // Overflow: output stalled, ticks accumulate until saturation
        ref_en = 1'b1;
        for (int k = 1; k <= 96; k++) begin
            cyc();
            if (k == 10) check("ovf_no_ref_early", m_valid, 0);
            if (k == 16) check("ovf_pend_1", ref_pending, 1);
            if (k == 17) begin
                check("ovf_ref_valid", m_valid, 1);
                check("ovf_ref_data", m_data, REF_W);
                check("ovf_pend_taken", ref_pending, 0);
            end
            if (k == 50) check("ovf_host_blocked", h_ready, 0);
            if (k == 64) check("ovf_pend_3", ref_pending, 3);
            if (k == 95) begin
                check("ovf_pend_sat", ref_pending, 4);
                check("ovf_flag_clear", ref_overflow, 0);
            end
            if (k == 96) begin
                check("ovf_flag_set", ref_overflow, 1);
                check("ovf_pend_held", ref_pending, 4);
                check("ovf_data_stable", m_data, REF_W);
            end
        end
        ref_en = 1'b0;
        cyc();
        check("ovf_dis_pend", ref_pending, 0);
        check("ovf_sticky", ref_overflow, 1);

        m_ready = 1'b1;
        cyc();
        check("ovf_ref_accepted", m_valid, 0);
        check("hold_0", h_ready, 0);
`ifdef SDDT_REF_ARB_STATS_EN
        check("stat_issued_1", ref_issued_cnt, 1);
        check("stat_forced_0", ref_forced_cnt, 0);
`endif
        cyc();
        cyc();
        check("hold_2", h_ready, 0);
        cyc();
        check("hold_done", h_ready, 1);

        // Reset asserted mid-transfer
        h_valid = 1'b1;
        h_data  = 128'hCAFE_0001;
        m_ready = 1'b0;
        cyc();
        check("mid_valid", m_valid, 1);
        check("mid_data", m_data, 128'hCAFE_0001);
        #3 rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_m_data", m_data, 0);
        check("arst_pending", ref_pending, 0);
        check("arst_overflow", ref_overflow, 0);
        check("arst_h_ready", h_ready, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1 check("rel_h_ready", h_ready, 0);
        cyc();
        check("rel_e1_m_valid", m_valid, 0);
        check("rel_e1_h_ready", h_ready, 1);
        cyc();
        check("rel_resend_valid", m_valid, 1);
        check("rel_resend_data", m_data, 128'hCAFE_0001);
        m_ready = 1'b1;
        h_valid = 1'b0;
        cyc();
        check("rel_drained", m_valid, 0);

        // Pass-through, refresh disabled
        for (int i = 0; i < 16; i++) begin
            h_valid = 1'b1;
            h_data  = {4{32'hB000_0000 + i}};
            #1 check("pt_h_ready", h_ready, 1);
            cyc();
            check("pt_valid", m_valid, 1);
            check("pt_data", m_data, {4{32'hB000_0000 + i}});
        end
        h_valid = 1'b0;
        cyc();
        check("pt_end_valid", m_valid, 0);

        // Backpressure
        m_ready = 1'b0;
        h_valid = 1'b1;
        h_data  = beat(0);
        #1 check("bp_first_ready", h_ready, 1);
        cyc();
        check("bp_first_data", m_data, beat(0));
        h_data = beat(1);
        for (int c = 0; c < 20; c++) begin
            #1 check("bp_h_ready", h_ready, 0);
            cyc();
            check("bp_hold_valid", m_valid, 1);
            check("bp_hold_data", m_data, beat(0));
        end
        m_ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            h_data = beat(j);
            #1 check("bp_rel_ready", h_ready, 1);
            cyc();
            check("bp_rel_data", m_data, beat(j));
        end
        h_valid = 1'b0;
        cyc();
        check("bp_drained", m_valid, 0);

        // Opportunistic refresh with idle host
        do_reset();
        ref_en = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            cyc();
            if (k == 15) check("opp_pend_0", ref_pending, 0);
            if (k == 16) begin
                check("opp_pend_1", ref_pending, 1);
                check("opp_no_ref_yet", m_valid, 0);
            end
            if (k == 17) begin
                check("opp_ref_valid", m_valid, 1);
                check("opp_ref_data", m_data, REF_W);
                check("opp_pend_back", ref_pending, 0);
                check("opp_wait_block", h_ready, 0);
            end
            if (k == 18) begin
                check("opp_accepted", m_valid, 0);
                check("opp_hold_block", h_ready, 0);
            end
            if (k == 20) check("opp_hold_last", h_ready, 0);
            if (k == 21) check("opp_host_open", h_ready, 1);
            if (k == 33) begin
                check("opp_ref2_valid", m_valid, 1);
                check("opp_ref2_data", m_data, REF_W);
            end
            if (k == 34) check("opp_ref2_accepted", m_valid, 0);
        end
`ifdef SDDT_REF_ARB_STATS_EN
        check("stat_issued_2", ref_issued_cnt, 2);
`endif

        // Forced refresh with host always valid
        ref_en  = 1'b0;
        h_valid = 1'b1;
        h_data  = {4{32'hD00D_0001}};
        do_reset();
        ref_en = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            cyc();
            if (k == 16) begin
                check("frc_pend_1", ref_pending, 1);
                check("frc_host_data", m_data, {4{32'hD00D_0001}});
            end
            if (k == 48) check("frc_pend_3", ref_pending, 3);
            if (k == 63) check("frc_host_ready", h_ready, 1);
            if (k == 64) begin
                check("frc_pend_4", ref_pending, 4);
                check("frc_block", h_ready, 0);
                check("frc_last_host", m_data, {4{32'hD00D_0001}});
            end
            if (k == 65) begin
                check("frc_ref_valid", m_valid, 1);
                check("frc_ref_data", m_data, REF_W);
                check("frc_pend_dec", ref_pending, 3);
                check("frc_wait_block", h_ready, 0);
`ifdef SDDT_REF_ARB_STATS_EN
                check("stat_forced_1", ref_forced_cnt, 1);
`endif
            end
            if (k == 66) check("frc_accepted", m_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
